mc_main_ctrl: RTL and testbench
===============================

Name: mc_main_ctrl

Overview:
- Multicycle main-control FSM for the MIPS-style datapath; sits directly upstream of the ALU control decoder.
- Consumes the latched opcode and the ALU zero flag `z`. Produces `ALUop` for the ALU control decoder, plus all datapath/memory enables.
- Sequences fetch/decode/execute/memory/writeback, stalling on a memory-ready handshake.

Parameters:
- STATE_W, 4, width of state register and `state_dbg` port.
- MEM_WAIT_MAX, 15, max cycles waited for `mem_ready` in one memory state before fault.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction[31:26] from IR; valid from DECODE onward
- z  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- ALUop  out  5  to ALU control decoder
- pc_write  out  1  PC load enable, branch condition already resolved
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  writeback source: 1 = MDR
- reg_dst  out  1  destination: 1 = rd, 0 = rt
- reg_write  out  1  register file write
- alu_src_a  out  1  A source: 0 = PC, 1 = regA
- alu_src_b  out  2  B source: 00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- pc_source  out  2  PC source: 00 ALU, 01 ALUOut, 10 jump target, 11 exception vector
- fault  out  1  sticky fault flag
- state_dbg  out  STATE_W  current state

Behaviour:
- **Reset:** async reset → state FETCH, wait counter 0, fault 0. While rst_n = 0, every output except state_dbg is forced to 0.
- **States and encodings:** FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, RTWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11, TRAP 12. Unused encodings go to FETCH.
- **ALUop encodings:**
  - 00 ADD
  - 01 SUB
  - 02 R-type (funct decides, including custom funct 0x32)
  - 03 AND
  - 04 OR
  - 05 SLT
- **FETCH:** mem_read = 1, IorD = 0, alu_src_a = 0, alu_src_b = 01, ALUop = ADD. ir_write and pc_write (pc_source 00) assert only in the cycle mem_ready = 1, then → DECODE. Otherwise stay.
- **DECODE:** alu_src_a = 0, alu_src_b = 11, ALUop = ADD (branch target into ALUOut). Next state by opcode:
  - 0x00 → RTEXEC
  - 0x23 / 0x2B → MEMADR
  - 0x04 / 0x05 → BRANCH
  - 0x02 → JUMP
  - 0x08 / 0x0C / 0x0D / 0x0A → IEXEC
  - other → see optional feature
- **MEMADR:** alu_src_a = 1, alu_src_b = 10, ALUop = ADD. → MEMRD for 0x23, MEMWR for 0x2B.
- **MEMRD:** mem_read = 1, IorD = 1. On mem_ready → MEMWB.
- **MEMWB:** reg_write = 1, mem_to_reg = 1, reg_dst = 0. → FETCH.
- **MEMWR:** mem_write = 1, IorD = 1. On mem_ready → FETCH.
- **RTEXEC:** alu_src_a = 1, alu_src_b = 00, ALUop = 02. → RTWB.
- **RTWB:** reg_write = 1, reg_dst = 1, mem_to_reg = 0. → FETCH.
- **BRANCH:** alu_src_a = 1, alu_src_b = 00, ALUop = SUB, pc_source = 01. pc_write = z for 0x04, pc_write = !z for 0x05. → FETCH.
- **JUMP:** pc_write = 1, pc_source = 10. → FETCH.
- **IEXEC:** alu_src_a = 1, alu_src_b = 10. ALUop by opcode: 0x08 ADD, 0x0C AND, 0x0D OR, 0x0A SLT. → IWB.
- **IWB:** reg_write = 1, reg_dst = 0. → FETCH.
- **Memory wait:** counter clears on entering FETCH, MEMRD or MEMWR and increments each cycle mem_ready = 0. If it reaches MEM_WAIT_MAX with mem_ready still 0: fault ← 1, → TRAP. mem_ready = 1 on the final count still completes normally.
- **Opcode sampling:** opcode is sampled only in DECODE; it is registered there for use in later states.
- **Output gating:** outputs are combinational from state; memory-state outputs are additionally gated by mem_ready as stated above.
- **Simultaneous events:** mem_ready outside a memory state is ignored.
- **TRAP:** pc_write = 1, pc_source = 11. → FETCH. fault stays 1 until reset.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined: unknown opcode in DECODE → TRAP and fault ← 1.
- Undefined: unknown opcode executes as NOP (DECODE → FETCH, no writes). Memory timeout still → TRAP.

Decomposition:
- Shared package `mc_ctrl_pkg` holds:
  - state encodings
  - opcode constants
  - ALUop constants (02 shared with the ALU control decoder)
  - alu_src_b and pc_source encodings
- One sub-module, `mc_ctrl_outdec`: pure state/opcode/z/mem_ready → control-word decoder, kept separate from the next-state logic.

Test Plan:
- **R-type flow:** reset, opcode 0x00, mem_ready = 1 → states 0,1,6,7,0 across 4 cycles; ALUop = 02 in RTEXEC; reg_write = 1 and reg_dst = 1 in RTWB.
- **lw with stall:** opcode 0x23, mem_ready held 0 for 3 cycles in MEMRD → stays in state 3 for 4 cycles, then MEMWB with mem_to_reg = 1. Total 5 + 3 cycles.
- **Branches:**
  - beq, z = 1 → pc_write = 1, pc_source = 01.
  - beq, z = 0 → pc_write = 0.
  - bne, z = 0 → pc_write = 1.
- **Immediates:** ori (0x0D) → ALUop = 04 in IEXEC; slti (0x0A) → ALUop = 05.
- **Timeout:** mem_ready = 0 forever in FETCH → TRAP after 15 cycles, pc_source = 11, fault stays 1 until rst_n pulse.
- **Reset mid-operation:** rst_n low during MEMWR with mem_write = 1 → all outputs 0 immediately, state 0. Illegal opcode 0x3F → TRAP with MC_ILLEGAL_TRAP_EN, FETCH without it.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle main controller: states, opcodes,
// ALUop values (shared with the ALU control decoder) and mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [4:0] ALUOP_ADD   = 5'd0;
    localparam logic [4:0] ALUOP_SUB   = 5'd1;
    localparam logic [4:0] ALUOP_RTYPE = 5'd2;
    localparam logic [4:0] ALUOP_AND   = 5'd3;
    localparam logic [4:0] ALUOP_OR    = 5'd4;
    localparam logic [4:0] ALUOP_SLT   = 5'd5;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    // States that wait on the memory handshake and run the timeout counter.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Pure control-word decoder: current state, latched opcode, zero flag and
// mem_ready in, datapath/memory enables out. No state of its own.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic [5:0] op_i,
    input  logic       z_i,
    input  logic       mem_ready_i,
    output logic [4:0] alu_op_o,
    output logic       pc_write_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] pc_source_o
);

    // Control word per state; everything idles at zero unless the state drives it.
    always_comb begin
        alu_op_o     = ALUOP_ADD;
        pc_write_o   = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_dst_o    = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRCB_REGB;
        pc_source_o  = PCSRC_ALU;
        case (state_i)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                end else begin
                    ir_write_o = 1'b0;
                    pc_write_o = 1'b0;
                end
            end
            S_DECODE: alu_src_b_o = SRCB_IMM_SH2;
            S_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            S_MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            S_MEMWR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
            end
            S_RTEXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALUOP_RTYPE;
            end
            S_RTWB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALUOP_SUB;
                pc_source_o = PCSRC_ALUOUT;
                if (op_i == OP_BEQ) begin
                    pc_write_o = z_i;
                end else if (op_i == OP_BNE) begin
                    pc_write_o = ~z_i;
                end else begin
                    pc_write_o = 1'b0;
                end
            end
            S_JUMP: begin
                pc_write_o  = 1'b1;
                pc_source_o = PCSRC_JUMP;
            end
            S_IEXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                case (op_i)
                    OP_ANDI: alu_op_o = ALUOP_AND;
                    OP_ORI:  alu_op_o = ALUOP_OR;
                    OP_SLTI: alu_op_o = ALUOP_SLT;
                    default: alu_op_o = ALUOP_ADD;
                endcase
            end
            S_IWB:   reg_write_o = 1'b1;
            S_TRAP: begin
                pc_write_o  = 1'b1;
                pc_source_o = PCSRC_EXC;
            end
            default: alu_op_o = ALUOP_ADD;
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS-style main control FSM with memory-ready timeout.
// Build option: MC_ILLEGAL_TRAP_EN traps unknown opcodes instead of treating them as NOPs.
module mc_main_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W      = 4,
    parameter int MEM_WAIT_MAX = 15
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               z,
    input  logic               mem_ready,
    output logic [4:0]         ALUop,
    output logic               pc_write,
    output logic               IorD,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic               fault,
    output logic [STATE_W-1:0] state_dbg
);

    localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              fault_q, fault_d;
    logic [5:0]        op_q, op_d;

    logic [4:0] alu_op_s;
    logic       pc_write_s, iord_s, mem_read_s, mem_write_s, ir_write_s;
    logic       mem_to_reg_s, reg_dst_s, reg_write_s, alu_src_a_s;
    logic [1:0] alu_src_b_s, pc_source_s;

    // Next-state, opcode latch and memory-wait supervision.
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        op_d    = op_q;
        wait_d  = {WAIT_W{1'b0}};
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_RTYPE:                         state_d = S_RTEXEC;
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_J:                             state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
                        fault_d = 1'b1;
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTEXEC: state_d = S_RTWB;
            S_RTWB:   state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_TRAP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase

        // A ready on the last permitted cycle still wins; only a miss there traps.
        if (is_mem_state(state_q) && !mem_ready) begin
            if (wait_q == WAIT_LAST) begin
                state_d = S_TRAP;
                fault_d = 1'b1;
                wait_d  = {WAIT_W{1'b0}};
            end else begin
                wait_d  = wait_q + WAIT_ONE;
            end
        end else begin
            wait_d = {WAIT_W{1'b0}};
        end
    end

    // State, wait counter, sticky fault and latched opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= {WAIT_W{1'b0}};
            fault_q <= 1'b0;
            op_q    <= 6'h00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            op_q    <= op_d;
        end
    end

    mc_ctrl_outdec u_outdec (
        .state_i      (state_q),
        .op_i         (op_q),
        .z_i          (z),
        .mem_ready_i  (mem_ready),
        .alu_op_o     (alu_op_s),
        .pc_write_o   (pc_write_s),
        .iord_o       (iord_s),
        .mem_read_o   (mem_read_s),
        .mem_write_o  (mem_write_s),
        .ir_write_o   (ir_write_s),
        .mem_to_reg_o (mem_to_reg_s),
        .reg_dst_o    (reg_dst_s),
        .reg_write_o  (reg_write_s),
        .alu_src_a_o  (alu_src_a_s),
        .alu_src_b_o  (alu_src_b_s),
        .pc_source_o  (pc_source_s)
    );

    // Hold every control line low while reset is asserted, even though FETCH drives some.
    assign ALUop      = rst_n ? alu_op_s     : 5'd0;
    assign pc_write   = rst_n ? pc_write_s   : 1'b0;
    assign IorD       = rst_n ? iord_s       : 1'b0;
    assign mem_read   = rst_n ? mem_read_s   : 1'b0;
    assign mem_write  = rst_n ? mem_write_s  : 1'b0;
    assign ir_write   = rst_n ? ir_write_s   : 1'b0;
    assign mem_to_reg = rst_n ? mem_to_reg_s : 1'b0;
    assign reg_dst    = rst_n ? reg_dst_s    : 1'b0;
    assign reg_write  = rst_n ? reg_write_s  : 1'b0;
    assign alu_src_a  = rst_n ? alu_src_a_s  : 1'b0;
    assign alu_src_b  = rst_n ? alu_src_b_s  : 2'b00;
    assign pc_source  = rst_n ? pc_source_s  : 2'b00;
    assign fault      = rst_n ? fault_q      : 1'b0;
    assign state_dbg  = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench for mc_main_ctrl: instruction-plan reference model,
// table of per-opcode vectors, directed corner sequences and random stimulus.
`timescale 1ns/1ps
module tb_mc_main_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       z = 1'b0;
    logic       mem_ready = 1'b0;
    logic [4:0] ALUop;
    logic       pc_write, IorD, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, fault;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] state_dbg;

    mc_main_ctrl #(.STATE_W(4), .MEM_WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .z(z), .mem_ready(mem_ready),
        .ALUop(ALUop), .pc_write(pc_write), .IorD(IorD), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .fault(fault),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: current step, wait count, sticky fault and the
    // remaining plan of steps for the instruction in flight.
    int         m_state;
    int         m_wait;
    logic       m_fault;
    logic [5:0] m_op;
    int         m_plan[$];

    logic [3:0]  obs_state;
    logic [18:0] obs_vec;

    logic [5:0] op_pool [11] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
                                 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h3F};

    typedef struct {
        logic [5:0] op;
        logic       zz;
        int         exp_state;
        logic [4:0] exp_aop;
        logic       exp_pcw;
        logic [1:0] exp_ps;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [18:0] dut_vec();
        return {ALUop, pc_write, IorD, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, fault};
    endfunction

    // Outputs each step must show, straight from the behaviour description.
    function automatic logic [18:0] exp_out(input int st, input logic [5:0] op,
                                            input logic zz, input logic mr, input logic flt);
        logic [4:0] aop;
        logic pcw, iord, mrd, mwr, irw, m2r, rdst, rw, sa;
        logic [1:0] sb, ps;
        aop = 5'd0; pcw = 1'b0; iord = 1'b0; mrd = 1'b0; mwr = 1'b0; irw = 1'b0;
        m2r = 1'b0; rdst = 1'b0; rw = 1'b0; sa = 1'b0; sb = 2'b00; ps = 2'b00;
        case (st)
            0:  begin mrd = 1'b1; sb = 2'b01; irw = mr; pcw = mr; end
            1:  sb = 2'b11;
            2:  begin sa = 1'b1; sb = 2'b10; end
            3:  begin mrd = 1'b1; iord = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin mwr = 1'b1; iord = 1'b1; end
            6:  begin sa = 1'b1; aop = 5'd2; end
            7:  begin rw = 1'b1; rdst = 1'b1; end
            8:  begin
                    sa = 1'b1; aop = 5'd1; ps = 2'b01;
                    pcw = (op == 6'h04) ? zz : ((op == 6'h05) ? ~zz : 1'b0);
                end
            9:  begin pcw = 1'b1; ps = 2'b10; end
            10: begin
                    sa = 1'b1; sb = 2'b10;
                    aop = (op == 6'h0C) ? 5'd3 : (op == 6'h0D) ? 5'd4 : (op == 6'h0A) ? 5'd5 : 5'd0;
                end
            11: rw = 1'b1;
            12: begin pcw = 1'b1; ps = 2'b11; end
            default: aop = 5'd0;
        endcase
        return {aop, pcw, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ps, flt};
    endfunction

    task automatic model_reset();
        m_state = 0; m_wait = 0; m_fault = 1'b0; m_op = 6'h00;
        m_plan.delete();
    endtask

    task automatic model_advance(input logic [5:0] op, input logic mr);
        int nxt;
        if (m_state == 0 || m_state == 3 || m_state == 5) begin
            if (mr) begin
                if (m_state == 0) nxt = 1;
                else nxt = (m_plan.size() > 0) ? m_plan.pop_front() : 0;
            end else begin
                m_wait++;
                if (m_wait >= 15) begin
                    nxt = 12; m_fault = 1'b1; m_plan.delete();
                end else begin
                    nxt = m_state;
                end
            end
        end else if (m_state == 1) begin
            m_op = op;
            m_plan.delete();
            case (op)
                6'h00: begin m_plan.push_back(6); m_plan.push_back(7); end
                6'h23: begin m_plan.push_back(2); m_plan.push_back(3); m_plan.push_back(4); end
                6'h2B: begin m_plan.push_back(2); m_plan.push_back(5); end
                6'h04, 6'h05: m_plan.push_back(8);
                6'h02: m_plan.push_back(9);
                6'h08, 6'h0C, 6'h0D, 6'h0A: begin m_plan.push_back(10); m_plan.push_back(11); end
                default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                    m_plan.push_back(12); m_fault = 1'b1;
`endif
                end
            endcase
            nxt = (m_plan.size() > 0) ? m_plan.pop_front() : 0;
        end else begin
            nxt = (m_plan.size() > 0) ? m_plan.pop_front() : 0;
        end
        if (nxt != m_state) m_wait = 0;
        m_state = nxt;
    endtask

    // One clock: drive, compare on the falling edge, advance model on the rising edge.
    task automatic step(input logic [5:0] op, input logic zz, input logic mr);
        logic [18:0] exp_v;
        opcode = op; z = zz; mem_ready = mr;
        @(negedge clk);
        exp_v = exp_out(m_state, m_op, zz, mr, m_fault);
        obs_state = state_dbg;
        obs_vec = dut_vec();
        check("state", 32'(state_dbg), m_state);
        check("outputs", 32'(obs_vec), 32'(exp_v));
        @(posedge clk);
        model_advance(op, mr);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; opcode = 6'h00; z = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("rst_outputs", 32'(dut_vec()), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_state != 0 && n < 12) begin
            step(6'h00, 1'b0, 1'b1);
            n++;
        end
        if (m_state != 0) begin
            failures++;
            $display("FAIL drain: model did not return to FETCH, state %0d", m_state);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{6'h00, 1'b0, 6,  5'd2, 1'b0, 2'b00};
        tbl[1]  = '{6'h23, 1'b0, 2,  5'd0, 1'b0, 2'b00};
        tbl[2]  = '{6'h2B, 1'b1, 2,  5'd0, 1'b0, 2'b00};
        tbl[3]  = '{6'h04, 1'b1, 8,  5'd1, 1'b1, 2'b01};
        tbl[4]  = '{6'h04, 1'b0, 8,  5'd1, 1'b0, 2'b01};
        tbl[5]  = '{6'h05, 1'b0, 8,  5'd1, 1'b1, 2'b01};
        tbl[6]  = '{6'h05, 1'b1, 8,  5'd1, 1'b0, 2'b01};
        tbl[7]  = '{6'h02, 1'b0, 9,  5'd0, 1'b1, 2'b10};
        tbl[8]  = '{6'h08, 1'b0, 10, 5'd0, 1'b0, 2'b00};
        tbl[9]  = '{6'h0C, 1'b0, 10, 5'd3, 1'b0, 2'b00};
        tbl[10] = '{6'h0D, 1'b1, 10, 5'd4, 1'b0, 2'b00};
        tbl[11] = '{6'h0A, 1'b0, 10, 5'd5, 1'b0, 2'b00};
`ifdef MC_ILLEGAL_TRAP_EN
        tbl[12] = '{6'h3F, 1'b0, 12, 5'd0, 1'b1, 2'b11};
`else
        tbl[12] = '{6'h3F, 1'b0, 0,  5'd0, 1'b0, 2'b00};
`endif

        model_reset();
        #2;
        do_reset();

        // Per-opcode vectors: fetch, decode, then inspect the first execute step.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].op, tbl[i].zz, 1'b1);
            step(tbl[i].op, tbl[i].zz, 1'b1);
            step(tbl[i].op, tbl[i].zz, 1'b0);
            check("tbl_state", 32'(obs_state), tbl[i].exp_state);
            check("tbl_aluop", 32'(obs_vec[18:14]), 32'(tbl[i].exp_aop));
            check("tbl_pc_write", 32'(obs_vec[13]), 32'(tbl[i].exp_pcw));
            check("tbl_pc_source", 32'(obs_vec[2:1]), 32'(tbl[i].exp_ps));
            drain();
        end

        // R-type flow 0,1,6,7,0.
        do_reset();
        step(6'h00, 1'b0, 1'b1);
        check("rt_fetch", 32'(obs_state), 32'd0);
        step(6'h00, 1'b0, 1'b1);
        check("rt_decode", 32'(obs_state), 32'd1);
        step(6'h00, 1'b0, 1'b1);
        check("rt_exec", 32'(obs_state), 32'd6);
        check("rt_exec_aluop", 32'(obs_vec[18:14]), 32'd2);
        step(6'h00, 1'b0, 1'b1);
        check("rt_wb", 32'(obs_state), 32'd7);
        check("rt_wb_regwrite", 32'(obs_vec[6]), 32'd1);
        check("rt_wb_regdst", 32'(obs_vec[7]), 32'd1);
        step(6'h00, 1'b0, 1'b0);
        check("rt_back", 32'(obs_state), 32'd0);

        // lw with a three-cycle stall in MEMRD.
        do_reset();
        step(6'h23, 1'b0, 1'b1);
        step(6'h23, 1'b0, 1'b1);
        step(6'h23, 1'b0, 1'b1);
        check("lw_memadr", 32'(obs_state), 32'd2);
        for (int k = 0; k < 4; k++) begin
            step(6'h23, 1'b0, (k == 3) ? 1'b1 : 1'b0);
            check("lw_memrd_hold", 32'(obs_state), 32'd3);
        end
        step(6'h23, 1'b0, 1'b1);
        check("lw_memwb", 32'(obs_state), 32'd4);
        check("lw_mem_to_reg", 32'(obs_vec[8]), 32'd1);

        // Ready on the final permitted cycle still completes.
        do_reset();
        for (int k = 0; k < 14; k++) step(6'h00, 1'b0, 1'b0);
        step(6'h00, 1'b0, 1'b1);
        check("last_count_fetch", 32'(obs_state), 32'd0);
        step(6'h00, 1'b0, 1'b1);
        check("last_count_decode", 32'(obs_state), 32'd1);
        check("last_count_nofault", 32'(obs_vec[0]), 32'd0);
        drain();

        // Timeout in FETCH: 15 idle cycles then TRAP, fault sticky until reset.
        do_reset();
        for (int k = 0; k < 15; k++) step(6'h00, 1'b0, 1'b0);
        check("to_still_fetch", 32'(obs_state), 32'd0);
        step(6'h00, 1'b0, 1'b0);
        check("to_trap", 32'(obs_state), 32'd12);
        check("to_pc_source", 32'(obs_vec[2:1]), 32'd3);
        check("to_pc_write", 32'(obs_vec[13]), 32'd1);
        check("to_fault", 32'(obs_vec[0]), 32'd1);
        for (int k = 0; k < 3; k++) step(6'h00, 1'b0, 1'b0);
        check("to_fault_sticky", 32'(obs_vec[0]), 32'd1);
        do_reset();
        step(6'h00, 1'b0, 1'b0);
        check("to_fault_cleared", 32'(obs_vec[0]), 32'd0);

        // Asynchronous reset in the middle of a store.
        do_reset();
        step(6'h2B, 1'b0, 1'b1);
        step(6'h2B, 1'b0, 1'b1);
        step(6'h2B, 1'b0, 1'b1);
        opcode = 6'h2B; mem_ready = 1'b0;
        #2;
        check("midrst_memwrite_before", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", 32'(dut_vec()), 32'd0);
        check("midrst_state", 32'(state_dbg), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Random traffic with varying memory latency.
        for (int blk = 0; blk < 4; blk++) begin
            int thr;
            thr = (blk == 0) ? 90 : (blk == 1) ? 60 : (blk == 2) ? 6 : 75;
            for (int c = 0; c < 120; c++) begin
                int pick;
                logic [5:0] rop;
                logic rmr, rz;
                pick = $urandom_range(0, 11);
                if (pick == 11) rop = 6'($urandom_range(0, 63));
                else rop = op_pool[pick];
                rmr = ($urandom_range(0, 99) < thr) ? 1'b1 : 1'b0;
                rz  = 1'($urandom_range(0, 1));
                step(rop, rz, rmr);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
